// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-enable input plus counter/sync/blank/strobe bundle of the timing generator
interface vga_timing_if #(parameter int CNT_W = 11);
  logic             pix_en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             de;
  logic             line_start;
  logic             frame_start;
  logic [11:0]      rgb;
  modport master (
    input  pix_en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start, rgb
  );
  modport slave (
    output pix_en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start, rgb
  );
endinterface

// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA timing generator with pixel enable, data enable and line/frame strobes
module vga_timing_param #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 11
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HB_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VB_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_field
    $error("vga_timing_param: every timing field must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > 30 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_param: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  logic [CNT_W-1:0] hn, vn;
  // Flags are decoded from the next position so they land in the same register stage as the counters.
  always_comb begin
    hn = (rst || vga.hcount == H_LAST) ? '0 : vga.hcount + 1'b1;
    vn = rst ? '0 : (vga.hcount != H_LAST) ? vga.vcount : (vga.vcount == V_LAST) ? '0 : vga.vcount + 1'b1;
  end
  always_ff @(posedge clk)
    if (rst || vga.pix_en) begin
      vga.hcount      <= hn;
      vga.vcount      <= vn;
      vga.hsync       <= (hn >= HS_START && hn <= HS_STOP) ? HSYNC_POL : !HSYNC_POL;
      vga.vsync       <= (vn >= VS_START && vn <= VS_STOP) ? VSYNC_POL : !VSYNC_POL;
      vga.hblnk       <= hn >= HB_START;
      vga.vblnk       <= vn >= VB_START;
      vga.de          <= hn < HB_START && vn < VB_START;
      vga.line_start  <= hn == '0;
      vga.frame_start <= hn == '0 && vn == '0;
    end
  assign vga.rgb = '0;
endmodule
